// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 receiver.
// Frame states, prefix bytes and the movement keys the game listens for.
package ps2_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } ps2_frame_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_O = 8'h44;

    // PS/2 frames carry odd parity over data plus parity bit
    function automatic logic odd_ok(
        input logic [7:0] b,
        input logic       p
    );
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines and debounces the clock line.
// Emits a one-cycle fall pulse on each accepted 1->0 clock edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_f;
    logic [CW-1:0] cnt;

    assign data_s = dat_sync[1];

    // cnt tracks how long the synced level has disagreed with clk_f
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_f    <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_f) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                clk_f <= clk_sync[1];
                cnt   <= '0;
                fall  <= clk_f;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: frame FSM with stall timeout, then a byte
// layer folding E0/F0 prefixes into keycode/press/extended.
module ps2_keycode_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       press,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_err
);

    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic             fall;
    logic             data_s;
    ps2_frame_state_t state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par_bit;
    logic [TW-1:0]    tmo_cnt;
    logic             byte_rdy;
    logic [7:0]       rx_byte;
    logic             ext_pend;
    logic             brk_pend;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fall    (fall),
        .data_s  (data_s)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= F_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            byte_rdy  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (state == F_IDLE || fall) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // A stalled device must not wedge the receiver mid-frame
            if (state != F_IDLE && !fall && tmo_cnt == TMO_MAX) begin
                state     <= F_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    F_IDLE: begin
                        if (!data_s) begin
                            state   <= F_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    F_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= F_PARITY;
                        end
                    end
                    F_PARITY: begin
                        par_bit <= data_s;
                        state   <= F_STOP;
                    end
                    F_STOP: begin
                        if (data_s && odd_ok(shreg, par_bit)) begin
                            byte_rdy <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= F_IDLE;
                    end
                    default: state <= F_IDLE;
                endcase
            end
        end
    end

    // A bad or aborted frame drops any prefix it may have belonged to
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keycode    <= '0;
            press      <= 1'b0;
            extended   <= 1'b0;
            code_valid <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (frame_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_rdy) begin
                unique case (1'b1)
                    (rx_byte == PS2_EXT):   ext_pend <= 1'b1;
                    (rx_byte == PS2_BREAK): brk_pend <= 1'b1;
                    default: begin
                        keycode    <= rx_byte;
                        press      <= ~brk_pend;
                        extended   <= ext_pend;
                        code_valid <= 1'b1;
                        ext_pend   <= 1'b0;
                        brk_pend   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
